// File: rtl/tensor_operand_dispatcher_if.sv
// Bus bundle for tensor_operand_dispatcher: upstream element stream, adder operand/result
// lines and the downstream result port.
interface tensor_operand_dispatcher_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic signed [3:0]  in_k;
    logic signed [7:0]  ele_0;
    logic signed [7:0]  ele_1;
    logic signed [7:0]  ele_2;
    logic signed [7:0]  ele_3;
    logic signed [3:0]  ele_k;
    logic               start;
    logic signed [15:0] result_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               err;
    logic [15:0]        group_cnt;

    modport slave (
        input  in_valid, in_data, in_k, result_in, out_ready,
        output in_ready, ele_0, ele_1, ele_2, ele_3, ele_k, start,
        output out_valid, out_data, err, group_cnt
    );

    modport master (
        output in_valid, in_data, in_k, result_in, out_ready,
        input  in_ready, ele_0, ele_1, ele_2, ele_3, ele_k, start,
        input  out_valid, out_data, err, group_cnt
    );
endinterface

// File: rtl/tensor_operand_dispatcher.sv
// Collects four signed elements plus a bias, issues them to the output adder, waits a fixed
// latency, captures and checks the adder result, then hands it downstream.
module tensor_operand_dispatcher #(
    parameter int unsigned RESULT_LATENCY = 1
) (
    input logic                        clk,
    input logic                        rst,
    tensor_operand_dispatcher_if.slave bus
);

    typedef enum logic [1:0] {StCollect, StIssue, StWait, StOutput} state_e;

    localparam logic [3:0] LatLoad = 4'(RESULT_LATENCY - 1);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0][7:0]    ele_q, ele_d;
    logic signed [3:0]  ele_k_q, ele_k_d;
    logic               start_q, start_d;
    logic [3:0]         lat_cnt_q, lat_cnt_d;
    logic signed [15:0] ref_sum_q, ref_sum_d;
    logic               out_valid_q, out_valid_d;
    logic signed [15:0] out_data_q, out_data_d;
    logic               err_q, err_d;
    logic [15:0]        group_cnt_q, group_cnt_d;
    logic signed [15:0] sum_now;

    assign sum_now = {{8{ele_q[0][7]}}, ele_q[0]} + {{8{ele_q[1][7]}}, ele_q[1]}
                   + {{8{ele_q[2][7]}}, ele_q[2]} + {{8{ele_q[3][7]}}, ele_q[3]}
                   + {{12{ele_k_q[3]}}, ele_k_q};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ele_d       = ele_q;
        ele_k_d     = ele_k_q;
        start_d     = 1'b0;
        lat_cnt_d   = lat_cnt_q;
        ref_sum_d   = ref_sum_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        group_cnt_d = group_cnt_q;

        case (state_q)
            StCollect: begin
                if (bus.in_valid) begin
                    ele_d[idx_q] = bus.in_data;
                    idx_d        = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        ele_k_d = bus.in_k;
                        start_d = 1'b1;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                ref_sum_d = sum_now;
                lat_cnt_d = LatLoad;
                state_d   = StWait;
            end
            StWait: begin
                if (lat_cnt_q == 4'd0) begin
                    out_data_d  = bus.result_in;
                    // Mismatched results are still forwarded; only the flag records it.
                    if (bus.result_in != ref_sum_q) begin
                        err_d = 1'b1;
                    end
                    out_valid_d = 1'b1;
                    state_d     = StOutput;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            StOutput: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    group_cnt_d = group_cnt_q + 16'd1;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StCollect;
            idx_q       <= 2'd0;
            ele_q       <= '0;
            ele_k_q     <= '0;
            start_q     <= 1'b0;
            lat_cnt_q   <= 4'd0;
            ref_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            group_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ele_q       <= ele_d;
            ele_k_q     <= ele_k_d;
            start_q     <= start_d;
            lat_cnt_q   <= lat_cnt_d;
            ref_sum_q   <= ref_sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            group_cnt_q <= group_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StCollect);
    assign bus.ele_0     = ele_q[0];
    assign bus.ele_1     = ele_q[1];
    assign bus.ele_2     = ele_q[2];
    assign bus.ele_3     = ele_q[3];
    assign bus.ele_k     = ele_k_q;
    assign bus.start     = start_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;
    assign bus.group_cnt = group_cnt_q;

endmodule

// File: tb/tb_tensor_operand_dispatcher.sv
// Directed bench for tensor_operand_dispatcher: latency-1 instance for the directed groups,
// latency-3 instance for a randomized-gap run against a queue of expected sums.
module tb_tensor_operand_dispatcher;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tensor_operand_dispatcher_if b1 ();
    tensor_operand_dispatcher_if b3 ();

    tensor_operand_dispatcher #(.RESULT_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    tensor_operand_dispatcher #(.RESULT_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] sum5(input logic signed [7:0] a, b, c, d,
                                                input logic signed [3:0] k);
        return 16'(int'(a) + int'(b) + int'(c) + int'(d) + int'(k));
    endfunction

    // Model adders: the result is only meaningful on the cycle the DUT should sample it.
    logic signed [15:0] fault1;
    logic signed [15:0] r1;
    logic signed [15:0] p3 [3];

    always @(posedge clk) begin
        r1 <= b1.start ? sum5(b1.ele_0, b1.ele_1, b1.ele_2, b1.ele_3, b1.ele_k) + fault1
                       : 16'sh5555;
        p3[0] <= b3.start ? sum5(b3.ele_0, b3.ele_1, b3.ele_2, b3.ele_3, b3.ele_k)
                          : 16'sh2aaa;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.result_in = r1;
    assign b3.result_in = p3[2];

    task automatic beat(input int d, input int k);
        b1.in_valid = 1'b1;
        b1.in_data  = 8'(d);
        b1.in_k     = 4'(k);
        @(negedge clk);
        b1.in_valid = 1'b0;
    endtask

    task automatic group1(input string tag, input int d0, d1, d2, d3, k, input int exp_data,
                          input int err_pre, input int exp_err, input int hold,
                          input int exp_gc);
        int waited;
        beat(d0, -1);
        beat(d1, -1);
        beat(d2, -1);
        check_val({tag, " no early start"}, b1.start, 0);
        beat(d3, k);
        check_val({tag, " start"}, b1.start, 1);
        check_val({tag, " in_ready issue"}, b1.in_ready, 0);
        check_val({tag, " ele_0"}, b1.ele_0, d0);
        check_val({tag, " ele_1"}, b1.ele_1, d1);
        check_val({tag, " ele_2"}, b1.ele_2, d2);
        check_val({tag, " ele_3"}, b1.ele_3, d3);
        check_val({tag, " ele_k"}, b1.ele_k, k);
        check_val({tag, " err before"}, b1.err, err_pre);
        waited = 0;
        while (!b1.out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, " latency"}, waited, 2);
        check_val({tag, " out_data"}, b1.out_data, exp_data);
        check_val({tag, " err"}, b1.err, exp_err);
        for (int i = 0; i < hold; i++) begin
            check_val({tag, " hold out_valid"}, b1.out_valid, 1);
            check_val({tag, " hold out_data"}, b1.out_data, exp_data);
            check_val({tag, " hold in_ready"}, b1.in_ready, 0);
            check_val({tag, " hold group_cnt"}, b1.group_cnt, exp_gc - 1);
            @(negedge clk);
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        check_val({tag, " out_valid drop"}, b1.out_valid, 0);
        check_val({tag, " in_ready back"}, b1.in_ready, 1);
        check_val({tag, " group_cnt"}, b1.group_cnt, exp_gc);
        check_val({tag, " out_data kept"}, b1.out_data, exp_data);
    endtask

    // Latency-3 scoreboard and downstream driver, all on the falling edge.
    logic signed [15:0] exp_q [$];
    bit  mon3_en = 1'b0;
    int  cyc = 0;
    int  start_cyc = 0;
    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        cyc++;
        b3.out_ready = mon3_en ? ($urandom_range(0, 3) != 0) : 1'b0;
        if (mon3_en) begin
            if (b3.start) start_cyc = cyc;
            if (b3.out_valid && !prev_ov) check_val("lat3 spacing", cyc - start_cyc, 4);
            if (b3.out_valid && b3.out_ready) begin
                check_val("lat3 pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_val("lat3 out_data", b3.out_data, exp_q.pop_front());
            end
        end
        prev_ov = b3.out_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [7:0] d [4];
        logic signed [3:0] k;
        int guard;

        rst = 1'b0;
        fault1 = 16'sd0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_k = '0; b1.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_k = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check_val("reset in_ready", b1.in_ready, 1);
        check_val("reset start", b1.start, 0);
        check_val("reset out_valid", b1.out_valid, 0);
        check_val("reset out_data", b1.out_data, 0);
        check_val("reset err", b1.err, 0);
        check_val("reset group_cnt", b1.group_cnt, 0);
        check_val("reset ele_0", b1.ele_0, 0);
        check_val("reset ele_3", b1.ele_3, 0);
        check_val("reset ele_k", b1.ele_k, 0);

        group1("single", 10, 20, 30, 40, 5, 105, 0, 0, 0, 1);
        group1("min", -128, -128, -128, -128, -8, -520, 0, 0, 0, 2);
        group1("max", 127, 127, 127, 127, 7, 515, 0, 0, 0, 3);
        group1("bp", 1, 1, 1, 1, 1, 5, 0, 0, 5, 4);
        group1("mm1", 2, 2, 2, 2, 0, 8, 0, 0, 0, 5);
        fault1 = 16'sd1;
        group1("mm2", 3, 3, 3, 3, 0, 13, 0, 1, 0, 6);
        fault1 = 16'sd0;
        group1("mm3", 1, 2, 3, 4, -2, 8, 1, 1, 0, 7);

        beat(5, -1);
        beat(5, -1);
        rst = 1'b0;
        #1;
        check_val("async reset group_cnt", b1.group_cnt, 0);
        check_val("async reset err", b1.err, 0);
        @(negedge clk);
        rst = 1'b1;
        group1("after rst", 1, 2, 3, 4, 0, 10, 0, 0, 0, 1);

        mon3_en = 1'b1;
        for (int g = 0; g < 100; g++) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                guard = 0;
                while (!b3.in_ready && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 100) check_val("lat3 in_ready timeout", guard, 0);
                d[i] = 8'($urandom_range(0, 255));
                k    = 4'($urandom_range(0, 15));
                b3.in_valid = 1'b1;
                b3.in_data  = d[i];
                b3.in_k     = k;
                @(negedge clk);
                b3.in_valid = 1'b0;
            end
            exp_q.push_back(sum5(d[0], d[1], d[2], d[3], k));
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("lat3 drained", exp_q.size(), 0);
        mon3_en = 1'b0;
        @(negedge clk);
        check_val("lat3 err", b3.err, 0);
        check_val("lat3 group_cnt", b3.group_cnt, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tensor_operand_dispatcher.md
# tensor_operand_dispatcher

Feeds the tensor output-adder stage. It collects one group of four signed 8-bit cross-product elements plus a signed 4-bit bias element `k` from an upstream serial valid/ready stream. It presents the group in parallel with a one-cycle `start` pulse, waits a fixed latency, then captures the adder's 16-bit result. The result goes to a downstream valid/ready port, and the block checks the result against a locally computed reference sum.

## Interface
Parameters:
- `RESULT_LATENCY`, default 1: cycles from the `start` cycle to the cycle `result_in` is valid. Legal range 1–15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserting it forces reset state immediately; deassertion is synchronous to `clk` upstream.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  8 signed  element value.
- `in_k`  in  4 signed  bias element; sampled only on the 4th beat of a group.
- `ele_0`..`ele_3`  out  8 signed each  elements in arrival order (beat 0 → `ele_0`).
- `ele_k`  out  4 signed  bias element.
- `start`  out  1  one-cycle compute request to the adder.
- `result_in`  in  16 signed  adder result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  16 signed  captured result.
- `err`  out  1  sticky mismatch flag.
- `group_cnt`  out  16  count of groups delivered downstream; wraps modulo 2^16.

## Operation
- States and transitions:
  - COLLECT → ISSUE on the 4th handshake of a group.
  - ISSUE lasts one cycle, then → WAIT.
  - WAIT → OUTPUT when the latency counter expires.
  - OUTPUT → COLLECT on the downstream handshake.
- Reset values: state COLLECT, beat index 0, all `ele_*` 0, `ele_k` 0, `start` 0, `out_valid` 0, `out_data` 0, `err` 0, `group_cnt` 0.
- COLLECT:
  - `in_ready`=1 in COLLECT only; it is 0 in every other state.
  - A handshake (`in_valid`&`in_ready`) writes `in_data` into `ele_[idx]` and increments the 2-bit index.
  - On idx=3 the handshake also captures `in_k` into `ele_k`, and the index wraps to 0.
- ISSUE: `start`=1 for exactly this cycle. The reference sum is computed in the same cycle:
  - sign-extend all five operands to 16 bits and add;
  - range −520..+515, so no overflow is possible.
- WAIT: the counter loads `RESULT_LATENCY`−1 on entry and decrements each cycle. At count 0:
  - `result_in` is latched into `out_data`;
  - `result_in` is compared with the reference sum, and `err` is set on inequality;
  - the state moves to OUTPUT.
- OUTPUT:
  - `out_valid`=1 until `out_valid`&`out_ready`.
  - On that handshake, `group_cnt` increments and the state returns to COLLECT.
  - `out_data` holds its value until the next capture.
- `err` is sticky; only `rst` clears it. A mismatched result is still delivered unchanged.
- `ele_*`/`ele_k` remain stable from ISSUE through the WAIT capture cycle. They change only on COLLECT handshakes.
- Reset mid-operation: the partial group or pending result is discarded, and no `start` or `out_valid` is generated for it.

## Timing
- Beat-to-beat acceptance is 1 per cycle in COLLECT; gaps in `in_valid` are allowed.
- 4th input handshake at cycle T:
  - `start`=1 at T+1;
  - `result_in` sampled at the end of cycle T+1+`RESULT_LATENCY`;
  - `out_valid` first high at T+2+`RESULT_LATENCY`.
- Minimum group period with `out_ready` tied high: 4 + 1 + `RESULT_LATENCY` + 1 cycles.
- `in_valid` during ISSUE/WAIT/OUTPUT is ignored, because `in_ready`=0. Upstream must hold its data.
- `out_ready` high before `out_valid` is harmless. The handshake completes in the first `out_valid` cycle.
- `group_cnt` wraps from 0xFFFF to 0x0000 with no flag.
- All outputs are registered; there is no combinational path from `in_*` to `out_*` or `start`.

## Test plan
- Single group: beats 10, 20, 30, 40 with `in_k`=5 on beat 4, model adder with latency 1. Required: `start` one cycle after beat 4, `ele_0..3`=10/20/30/40, `ele_k`=5, `out_data`=105, `err`=0, `group_cnt`=1.
- Extremes: four beats of −128 with k=−8, then four of +127 with k=+7. Required: `out_data`=−520 then +515, `err`=0.
- Backpressure: `out_ready` low for 5 cycles after `out_valid`. Required: `out_valid` and `out_data` held, `in_ready`=0 throughout, a single `group_cnt` increment.
- Mismatch: model returns sum+1 for group 2 of 3. Required: `err` rises at group 2 capture, stays 1 through group 3, and group 2 `out_data` equals the faulty value.
- Reset mid-collect: 2 beats, `rst` low for 1 cycle, then a full group 1, 2, 3, 4 with k=0. Required: no `start` before the new 4th beat, `out_data`=10, `group_cnt`=1.
- `RESULT_LATENCY`=3 with random `in_valid` gaps over 100 groups. Required: `start` → capture spacing is exactly 3 cycles, every `out_data` matches the model, `err`=0.
